// File: rtl/vga_sync_gen.sv
// VGA raster timing source: pixel prescaler, H/V counters and registered
// sync, blanking and frame strobes that always describe the same pixel.
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] HCount,
  output logic [9:0] VCount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_DISP       = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP       = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt_r;
  logic             div_wrap_s;
  logic [9:0]       h_next_s;
  logic [9:0]       v_next_s;
  logic             hsync_next_s;
  logic             vsync_next_s;
  logic             video_on_next_s;
  logic             frame_start_next_s;

  // Next raster position and the decodes for that position, so every output
  // registered on a tick refers to the same pixel.
  always_comb begin
    div_wrap_s = (div_cnt_r == DIV_LAST);
    h_next_s   = HCount;
    v_next_s   = VCount;
    if (HCount == H_LAST) begin
      h_next_s = 10'd0;
      if (VCount == V_LAST) begin
        v_next_s = 10'd0;
      end else begin
        v_next_s = VCount + 10'd1;
      end
    end else begin
      h_next_s = HCount + 10'd1;
      v_next_s = VCount;
    end
    hsync_next_s       = ~((h_next_s >= H_SYNC_FIRST) && (h_next_s <= H_SYNC_LAST));
    vsync_next_s       = ~((v_next_s >= V_SYNC_FIRST) && (v_next_s <= V_SYNC_LAST));
    video_on_next_s    = (h_next_s < H_DISP) && (v_next_s < V_DISP);
    frame_start_next_s = (h_next_s == 10'd0) && (v_next_s == 10'd0);
  end

  // Prescaler and raster state; the reset image reports pixel (0,0) as blanked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_r   <= DIV_ZERO;
      HCount      <= 10'd0;
      VCount      <= 10'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_tick <= div_wrap_s;
      if (div_wrap_s) begin
        div_cnt_r   <= DIV_ZERO;
        HCount      <= h_next_s;
        VCount      <= v_next_s;
        hsync       <= hsync_next_s;
        vsync       <= vsync_next_s;
        video_on    <= video_on_next_s;
        frame_start <= frame_start_next_s;
      end else begin
        div_cnt_r   <= div_cnt_r + DIV_ONE;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default timing plus two shrunken rasters (CLK_DIV=1
// and CLK_DIV=3) so whole frames fit in a short run.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       pt;
    logic       fs;
  } exp_t;

  logic clk;
  logic reset;

  logic [9:0] h0, v0, h1, v1, h2, v2;
  logic hs0, vs0, vo0, pt0, fs0;
  logic hs1, vs1, vo1, pt1, fs1;
  logic hs2, vs2, vo2, pt2, fs2;

  int   checks;
  int   errors;
  int   n;
  int   fs1_cnt;
  exp_t sb[$];

  vga_sync_gen dut0 (
    .clk(clk), .reset(reset), .HCount(h0), .VCount(v0), .hsync(hs0), .vsync(vs0),
    .video_on(vo0), .pixel_tick(pt0), .frame_start(fs0)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut1 (
    .clk(clk), .reset(reset), .HCount(h1), .VCount(v1), .hsync(hs1), .vsync(vs1),
    .video_on(vo1), .pixel_tick(pt1), .frame_start(fs1)
  );

  vga_sync_gen #(
    .CLK_DIV(3), .H_DISPLAY(5), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(2)
  ) dut2 (
    .clk(clk), .reset(reset), .HCount(h2), .VCount(v2), .hsync(hs2), .vsync(vs2),
    .video_on(vo2), .pixel_tick(pt2), .frame_start(fs2)
  );

  always #5 clk = ~clk;

  // Expected outputs n clock edges after reset release, derived from the tick count.
  function automatic exp_t model(input int nn, input int d, input int hd, input int hf,
                                 input int hsw, input int hb, input int vd, input int vf,
                                 input int vsw, input int vb);
    exp_t e;
    int k, ht, vt, h, v;
    k  = nn / d;
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    h  = k % ht;
    v  = (k / ht) % vt;
    e.h  = 10'(h);
    e.v  = 10'(v);
    e.pt = (nn > 0) && ((nn % d) == 0);
    if (k == 0) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.vo = 1'b0;
      e.fs = 1'b0;
    end else begin
      e.hs = !((h >= hd + hf) && (h < hd + hf + hsw));
      e.vs = !((v >= vd + vf) && (v < vd + vf + vsw));
      e.vo = (h < hd) && (v < vd);
      e.fs = e.pt && (h == 0) && (v == 0);
    end
    return e;
  endfunction

  task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%0d expected=%0d", tag, n, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  task automatic pop_cmp(input string tag, input exp_t obs);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb_empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      chk10({tag, "_h"}, obs.h, e.h);
      chk10({tag, "_v"}, obs.v, e.v);
      chk1({tag, "_hsync"}, obs.hs, e.hs);
      chk1({tag, "_vsync"}, obs.vs, e.vs);
      chk1({tag, "_video_on"}, obs.vo, e.vo);
      chk1({tag, "_pixel_tick"}, obs.pt, e.pt);
      chk1({tag, "_frame_start"}, obs.fs, e.fs);
    end
  endtask

  task automatic step_check();
    sb.push_back(model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33));
    sb.push_back(model(n, 1, 8, 2, 3, 2, 4, 1, 2, 1));
    sb.push_back(model(n, 3, 5, 1, 2, 1, 3, 1, 1, 2));
    pop_cmp("d0", {h0, v0, hs0, vs0, vo0, pt0, fs0});
    pop_cmp("d1", {h1, v1, hs1, vs1, vo1, pt1, fs1});
    pop_cmp("d2", {h2, v2, hs2, vs2, vo2, pt2, fs2});
  endtask

  initial begin
    clk     = 1'b0;
    reset   = 1'b1;
    checks  = 0;
    errors  = 0;
    n       = 0;
    fs1_cnt = 0;

    repeat (3) begin
      @(negedge clk);
      step_check();
    end
    reset = 1'b0;

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n++;
      step_check();
    end
    chk10("t1_pre_hcount", h0, 10'd300);

    // mid-line asynchronous reset, observed before the next clock edge
    #1 reset = 1'b1;
    #1 n = 0;
    chk10("t1_async_hcount", h0, 10'd0);
    chk1("t1_async_video_on", vo0, 1'b0);
    step_check();
    repeat (2) begin
      @(negedge clk);
      step_check();
    end
    reset = 1'b0;

    for (int i = 0; i < 3400; i++) begin
      @(negedge clk);
      n++;
      step_check();
      if (fs1) fs1_cnt++;
      if (n == 1) begin
        chk1("t1_no_tick_clk1", pt0, 1'b0);
        chk10("t1_hold_clk1", h0, 10'd0);
      end
      if (n == 2) begin
        chk1("t1_tick_clk2", pt0, 1'b1);
        chk10("t1_hcount_clk2", h0, 10'd1);
        chk1("t1_video_on_clk2", vo0, 1'b1);
      end
      if (n == 1280) chk1("t5_video_off_640", vo0, 1'b0);
      if (n == 1310) chk1("t2_hsync_hi_655", hs0, 1'b1);
      if (n == 1312) begin
        chk1("t2_hsync_lo_656", hs0, 1'b0);
        chk10("t2_hcount_656", h0, 10'd656);
      end
      if (n == 1502) chk1("t2_hsync_lo_751", hs0, 1'b0);
      if (n == 1504) chk1("t2_hsync_hi_752", hs0, 1'b1);
      if (n == 1600) begin
        chk10("t2_wrap_hcount", h0, 10'd0);
        chk10("t2_wrap_vcount", v0, 10'd1);
      end
    end
    chk10("t3_frame_count_d1", 10'(fs1_cnt), 10'(3400 / 120));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
